// File: rtl/forward_scoreboard.sv
// Forwarding and interlock unit: tracks in-flight register writers per post-issue
// stage, picks the EX operand source for each decode operand and stalls issue.
module forward_scoreboard #(
  parameter int NUM_STAGES = 3,
  parameter int NUM_SRC    = 2,
  parameter int REG_W      = 5,
  parameter int CNT_W      = 32,
  localparam int SEL_W     = $clog2(NUM_STAGES + 1)
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       issue_valid,
  input  logic                       issue_regw,
  input  logic [REG_W-1:0]           issue_rd,
  input  logic [SEL_W-1:0]           issue_lat,
  input  logic [NUM_SRC-1:0]         src_valid,
  input  logic [NUM_SRC*REG_W-1:0]   src_reg,
  input  logic                       flush,
  output logic                       stall,
  output logic                       ex_valid,
  output logic [NUM_SRC*SEL_W-1:0]   fwd_sel,
  output logic [CNT_W-1:0]           stall_count
);

  function automatic logic [SEL_W-1:0] norm_lat(input logic [SEL_W-1:0] lat);
    if (lat == '0) return SEL_W'(1);
    if (int'(lat) > NUM_STAGES) return SEL_W'(NUM_STAGES);
    return lat;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
    return (&val) ? val : val + CNT_W'(1);
  endfunction

  logic                vld_p   [1:NUM_STAGES];
  logic                regw_p  [1:NUM_STAGES];
  logic [REG_W-1:0]    rd_p    [1:NUM_STAGES];
  logic [SEL_W-1:0]    lat_p   [1:NUM_STAGES];

  logic                src_hit [NUM_SRC];
  logic [SEL_W-1:0]    src_k   [NUM_SRC];
  logic [SEL_W-1:0]    src_lat [NUM_SRC];
  logic [NUM_SRC-1:0]         blocked;
  logic [NUM_SRC*SEL_W-1:0]   next_sel;
  logic                       accept;

  // Decode: a producer in entry k has its result in stage k's output register
  // once k >= lat; the oldest entry is written to the register file this edge.
  always_comb begin
    blocked  = '0;
    next_sel = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      src_hit[i] = 1'b0;
      src_k[i]   = '0;
      src_lat[i] = '0;
      for (int k = NUM_STAGES; k >= 1; k--) begin
        if (vld_p[k] && regw_p[k] && rd_p[k] == src_reg[i*REG_W +: REG_W]) begin
          src_hit[i] = 1'b1;
          src_k[i]   = SEL_W'(k);
          src_lat[i] = lat_p[k];
        end
      end
      if (src_valid[i] && src_reg[i*REG_W +: REG_W] != '0 && src_hit[i] &&
          int'(src_k[i]) != NUM_STAGES) begin
        if (src_k[i] >= src_lat[i]) next_sel[i*SEL_W +: SEL_W] = src_k[i];
        else                        blocked[i] = 1'b1;
      end
    end
  end

  assign stall  = issue_valid & (|blocked) & ~flush;
  assign accept = issue_valid & ~stall & ~flush;

  // Stage shift register and EX-stage select register (control)
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int k = 1; k <= NUM_STAGES; k++) vld_p[k] <= 1'b0;
      ex_valid    <= 1'b0;
      fwd_sel     <= '0;
      stall_count <= '0;
    end else begin
      vld_p[1] <= accept;
      for (int k = 2; k <= NUM_STAGES; k++) vld_p[k] <= vld_p[k-1] & ~flush;
      ex_valid <= accept;
      fwd_sel  <= accept ? next_sel : '0;
      if (stall) stall_count <= sat_inc(stall_count);
    end
  end

  // Stage shift register (data, qualified by vld_p)
  always_ff @(posedge CLK) begin
    regw_p[1] <= issue_regw;
    rd_p[1]   <= issue_rd;
    lat_p[1]  <= norm_lat(issue_lat);
    for (int k = 2; k <= NUM_STAGES; k++) begin
      regw_p[k] <= regw_p[k-1];
      rd_p[k]   <= rd_p[k-1];
      lat_p[k]  <= lat_p[k-1];
    end
  end

endmodule

// File: tb/tb_forward_scoreboard.sv
// Bench for forward_scoreboard: directed vector table, randomized run against a
// timestamp-based reference model, and a 5-stage / 3-source instance.
module tb_forward_scoreboard;
  localparam int NA = 3;
  localparam int NB = 5;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  // instance A: 3 stages, 2 sources
  logic        rst_a, a_iv, a_rw, a_fl, a_stall, a_exv;
  logic [4:0]  a_rd;
  logic [1:0]  a_lat, a_sv;
  logic [9:0]  a_sr;
  logic [3:0]  a_sel;
  logic [31:0] a_cnt;

  // instance B: 5 stages, 3 sources, 3-bit counter
  logic        rst_b, b_iv, b_rw, b_fl, b_stall, b_exv;
  logic [4:0]  b_rd;
  logic [2:0]  b_lat, b_sv, b_cnt;
  logic [14:0] b_sr;
  logic [8:0]  b_sel;

  forward_scoreboard #(.NUM_STAGES(NA), .NUM_SRC(2), .REG_W(5), .CNT_W(32)) dut_a (
    .CLK(CLK), .RST(rst_a), .issue_valid(a_iv), .issue_regw(a_rw), .issue_rd(a_rd),
    .issue_lat(a_lat), .src_valid(a_sv), .src_reg(a_sr), .flush(a_fl),
    .stall(a_stall), .ex_valid(a_exv), .fwd_sel(a_sel), .stall_count(a_cnt));

  forward_scoreboard #(.NUM_STAGES(NB), .NUM_SRC(3), .REG_W(5), .CNT_W(3)) dut_b (
    .CLK(CLK), .RST(rst_b), .issue_valid(b_iv), .issue_regw(b_rw), .issue_rd(b_rd),
    .issue_lat(b_lat), .src_valid(b_sv), .src_reg(b_sr), .flush(b_fl),
    .stall(b_stall), .ex_valid(b_exv), .fwd_sel(b_sel), .stall_count(b_cnt));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  typedef struct {
    logic iv, rw; logic [4:0] rd; logic [1:0] lat; logic [1:0] sv;
    logic [4:0] s0, s1; logic fl, rst;
    logic e_st, e_ev; logic [1:0] e0, e1; int e_cnt;
  } vec_t;

  function automatic vec_t mk(input logic iv, rw, input logic [4:0] rd, input logic [1:0] lat,
                              input logic [1:0] sv, input logic [4:0] s0, s1, input logic fl,
                              input logic e_st, e_ev, input logic [1:0] e0, e1, input int e_cnt);
    vec_t v;
    v.iv = iv; v.rw = rw; v.rd = rd; v.lat = lat; v.sv = sv; v.s0 = s0; v.s1 = s1;
    v.fl = fl; v.rst = 1'b0; v.e_st = e_st; v.e_ev = e_ev; v.e0 = e0; v.e1 = e1;
    v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic apply_a(input vec_t v, input string tag);
    @(negedge CLK);
    rst_a = v.rst; a_iv = v.iv; a_rw = v.rw; a_rd = v.rd; a_lat = v.lat;
    a_sv = v.sv; a_sr = {v.s1, v.s0}; a_fl = v.fl;
    #1 chk({tag, ".stall"}, a_stall, v.e_st);
    @(posedge CLK);
    #1;
    chk({tag, ".ex_valid"}, a_exv, v.e_ev);
    chk({tag, ".fwd_sel"}, a_sel, {v.e1, v.e0});
    chk({tag, ".stall_count"}, a_cnt, v.e_cnt);
  endtask

  task automatic apply_b(input logic iv, rw, input logic [4:0] rd, input logic [2:0] lat,
                         input logic [2:0] sv, input logic [4:0] s0, s1, s2, input logic rst,
                         input logic e_st, e_ev, input logic [8:0] e_sel, input int e_cnt,
                         input string tag);
    @(negedge CLK);
    rst_b = rst; b_iv = iv; b_rw = rw; b_rd = rd; b_lat = lat; b_sv = sv;
    b_sr = {s2, s1, s0}; b_fl = 1'b0;
    #1 chk({tag, ".stall"}, b_stall, e_st);
    @(posedge CLK);
    #1;
    chk({tag, ".ex_valid"}, b_exv, e_ev);
    chk({tag, ".fwd_sel"}, b_sel, e_sel);
    chk({tag, ".stall_count"}, b_cnt, e_cnt);
  endtask

  // Reference model: list of accepted writers stamped with their issue cycle.
  typedef struct { int cyc; logic rw; logic [4:0] rd; int lat; } wr_t;
  wr_t wq[$];
  int  cyc_a;

  function automatic void decide(input logic sv, input logic [4:0] s,
                                 output int sel, output logic blk);
    int best = 0;
    int blat = 0;
    sel = 0;
    blk = 1'b0;
    foreach (wq[j]) begin
      int age = cyc_a - wq[j].cyc;
      if (age >= 1 && age <= NA && wq[j].rw && wq[j].rd == s && (best == 0 || age < best)) begin
        best = age;
        blat = wq[j].lat;
      end
    end
    if (!sv || s == 5'd0 || best == 0 || best == NA) return;
    if (best >= blat) sel = best;
    else blk = 1'b1;
  endfunction

  vec_t tbl[$];

  initial begin
    rst_a = 1'b1; a_iv = 0; a_rw = 0; a_rd = 0; a_lat = 0; a_sv = 0; a_sr = 0; a_fl = 0;
    rst_b = 1'b1; b_iv = 0; b_rw = 0; b_rd = 0; b_lat = 0; b_sv = 0; b_sr = 0; b_fl = 0;
    repeat (2) @(posedge CLK);
    #1;
    chk("reset_a.ex_valid", a_exv, 0);
    chk("reset_a.fwd_sel", a_sel, 0);
    chk("reset_a.stall_count", a_cnt, 0);
    chk("reset_b.ex_valid", b_exv, 0);
    chk("reset_b.fwd_sel", b_sel, 0);
    chk("reset_b.stall_count", b_cnt, 0);
    rst_b = 1'b0;

    // iv rw rd lat sv s0 s1 fl | stall ex_valid sel0 sel1 count
    tbl.push_back(mk(1,0, 0,0,2'b11, 3, 3,0, 0,1,0,0,0)); // empty after reset
    tbl.push_back(mk(1,1, 3,1,2'b00, 0, 0,0, 0,1,0,0,0)); // ALU r3
    tbl.push_back(mk(1,0, 0,0,2'b01, 3, 0,0, 0,1,1,0,0)); // back-to-back
    tbl.push_back(mk(1,1, 5,2,2'b00, 0, 0,0, 0,1,0,0,0)); // load r5
    tbl.push_back(mk(1,0, 0,0,2'b01, 5, 0,0, 1,0,0,0,1)); // load-use stall
    tbl.push_back(mk(1,0, 0,0,2'b01, 5, 0,0, 0,1,2,0,1));
    tbl.push_back(mk(1,1, 7,1,2'b00, 0, 0,0, 0,1,0,0,1)); // two r7 writers
    tbl.push_back(mk(1,1, 7,1,2'b00, 0, 0,0, 0,1,0,0,1));
    tbl.push_back(mk(1,0, 0,0,2'b11, 7, 7,0, 0,1,1,1,1));
    tbl.push_back(mk(1,1, 9,3,2'b00, 0, 0,0, 0,1,0,0,1)); // r9 lat 3
    tbl.push_back(mk(1,1, 0,3,2'b00, 0, 0,0, 0,1,0,0,1)); // r0 lat 3
    tbl.push_back(mk(1,0, 0,0,2'b01, 0, 9,0, 0,1,0,0,1)); // r0 + invalid src1
    tbl.push_back(mk(1,0, 0,0,2'b10, 0, 9,0, 0,1,0,0,1)); // r9 retiring -> RF
    tbl.push_back(mk(1,1,10,0,2'b00, 0, 0,0, 0,1,0,0,1)); // lat 0 -> 1
    tbl.push_back(mk(1,0, 0,0,2'b01,10, 0,0, 0,1,1,0,1));
    tbl.push_back(mk(1,1,12,1,2'b00, 0, 0,0, 0,1,0,0,1)); // r12
    tbl.push_back(mk(0,0, 0,0,2'b00, 0, 0,0, 0,0,0,0,1)); // idle
    tbl.push_back(mk(1,1,11,2,2'b00, 0, 0,0, 0,1,0,0,1)); // load r11
    tbl.push_back(mk(1,0, 0,0,2'b11,11,12,1, 0,0,0,0,1)); // flush in stall cycle
    tbl.push_back(mk(1,0, 0,0,2'b11,11,12,0, 0,1,0,0,1)); // r11 squashed, r12 in RF
    tbl.push_back(mk(1,1,13,1,2'b00, 0, 0,0, 1'b0,0,0,0,1)); // r13 writer issued with flush
    tbl[tbl.size()-1].fl = 1'b1;                           // flush overrides accept
    tbl.push_back(mk(1,0, 0,0,2'b01,13, 0,0, 0,1,0,0,1));
    tbl.push_back(mk(1,1,14,1,2'b00, 0, 0,0, 0,1,0,0,1));
    tbl.push_back(mk(1,1,15,2,2'b00, 0, 0,0, 0,1,0,0,1));
    tbl.push_back(mk(1,0, 0,0,2'b11,14,15,0, 1,0,0,0,2)); // src1 blocks whole instr
    tbl.push_back(mk(1,0, 0,0,2'b11,14,15,0, 0,1,0,2,2));
    tbl.push_back(mk(1,0,16,1,2'b00, 0, 0,0, 0,1,0,0,2)); // non-writer with rd 16
    tbl.push_back(mk(1,0, 0,0,2'b01,16, 0,0, 0,1,0,0,2));
    foreach (tbl[i]) apply_a(tbl[i], $sformatf("vec%0d", i));

    // Randomized run against the model; starts from a reset cycle.
    begin
      int cnt_m = 0;
      wq.delete();
      cyc_a = 0;
      for (int n = 0; n < 400; n++) begin
        vec_t v;
        int sel0, sel1, lat_m;
        logic blk0, blk1, acc;
        v.rst = (n == 0) || ($urandom_range(59) == 0);
        v.iv  = (n == 0) ? 1'b0 : ($urandom_range(9) < 8);
        v.rw  = $urandom_range(9) < 7;
        v.rd  = 5'($urandom_range(7));
        v.lat = 2'($urandom_range(3));
        v.sv  = 2'($urandom_range(3));
        v.s0  = 5'($urandom_range(7));
        v.s1  = 5'($urandom_range(7));
        v.fl  = $urandom_range(19) == 0;
        decide(v.sv[0], v.s0, sel0, blk0);
        decide(v.sv[1], v.s1, sel1, blk1);
        v.e_st = v.iv & (blk0 | blk1) & ~v.fl;
        acc    = v.iv & ~v.e_st & ~v.fl;
        v.e_ev = acc & ~v.rst;
        v.e0   = (acc && !v.rst) ? 2'(sel0) : 2'd0;
        v.e1   = (acc && !v.rst) ? 2'(sel1) : 2'd0;
        if (v.rst) cnt_m = 0;
        else if (v.e_st) cnt_m++;
        v.e_cnt = cnt_m;
        if (n == 0) v.e_st = 1'b0;
        apply_a(v, $sformatf("rnd%0d", n));
        lat_m = (v.lat == 0) ? 1 : ((int'(v.lat) > NA) ? NA : int'(v.lat));
        if (v.rst || v.fl) wq.delete();
        else if (acc) wq.push_back('{cyc_a, v.rw, v.rd, lat_m});
        cyc_a++;
        while (wq.size() > 0 && cyc_a - wq[0].cyc > NA) void'(wq.pop_front());
      end
    end

    // 5-stage, 3-source instance: lat 4 at d = 1, clamp of lat 7, saturation, reset.
    apply_b(1,1,4,4, 3'b000,0,0,0, 0, 0,1,9'd0,0, "b_prod4");
    apply_b(1,0,0,0, 3'b100,0,0,4, 0, 1,0,9'd0,1, "b_stall1");
    apply_b(1,0,0,0, 3'b100,0,0,4, 0, 1,0,9'd0,2, "b_stall2");
    apply_b(1,0,0,0, 3'b100,0,0,4, 0, 1,0,9'd0,3, "b_stall3");
    apply_b(1,0,0,0, 3'b100,0,0,4, 0, 0,1,9'd256,3, "b_sel4");
    apply_b(1,1,6,7, 3'b000,0,0,0, 0, 0,1,9'd0,3, "b_prod7");
    for (int j = 1; j <= 4; j++)
      apply_b(1,0,0,0, 3'b001,6,0,0, 0, 1,0,9'd0,3+j, $sformatf("b_clamp%0d", j));
    apply_b(1,0,0,0, 3'b001,6,0,0, 0, 0,1,9'd0,7, "b_clamp_rf");
    apply_b(1,1,8,4, 3'b000,0,0,0, 0, 0,1,9'd0,7, "b_prod8");
    for (int j = 1; j <= 3; j++)
      apply_b(1,0,0,0, 3'b010,0,8,0, 0, 1,0,9'd0,7, $sformatf("b_sat%0d", j));
    apply_b(1,0,0,0, 3'b010,0,8,0, 0, 0,1,9'd32,7, "b_sel4_src1");
    apply_b(1,1,4,4, 3'b000,0,0,0, 0, 0,1,9'd0,7, "b_prod4b");
    apply_b(1,0,0,0, 3'b100,0,0,4, 0, 1,0,9'd0,7, "b_stall_pre_rst");
    apply_b(1,0,0,0, 3'b100,0,0,4, 1, 1,0,9'd0,0, "b_rst_mid_stall");
    apply_b(1,0,0,0, 3'b100,0,0,4, 0, 0,1,9'd0,0, "b_after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
